// File: rtl/fxp_sqrt_seq.sv
// Sequential fixed-point square root, one root bit per clock.
// Radix-2 digit recurrence with valid/ready on both sides and tag pass-through.
module fxp_sqrt_seq #(
  parameter  int IN_W     = 12,
  parameter  int IN_FRAC  = 4,
  parameter  int OUT_FRAC = 16,
  parameter  int TAG_W    = 4,
  parameter  int ROUND    = 0,
  localparam int RAW      = IN_W + 2*OUT_FRAC - IN_FRAC,
  localparam int RW       = RAW + (RAW % 2),
  localparam int QW       = RW / 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    out_q,
  output logic             out_exact,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SH = 2*OUT_FRAC - IN_FRAC;
  localparam int IW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FIN, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [RW-1:0]    r_q, r_d;
  logic [QW-1:0]    q_q, q_d;
  logic [QW+1:0]    rem_q, rem_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [QW-1:0]    oq_q, oq_d;
  logic             oex_q, oex_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic             ovld_q, ovld_d;

  logic [QW+1:0] rem_sh;
  logic [QW+1:0] trial;
  logic          ge;
  logic          up;
  logic [QW-1:0] q_rnd;

  // State and datapath registers, all cleared by async reset
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      iter_q  <= '0;
      tag_q   <= '0;
      oq_q    <= '0;
      oex_q   <= 1'b0;
      otag_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
      tag_q   <= tag_d;
      oq_q    <= oq_d;
      oex_q   <= oex_d;
      otag_q  <= otag_d;
      ovld_q  <= ovld_d;
    end
  end

  // Next-state sequencing: accept, QW iterations, finish, handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_CALC;
      S_CALC: if (iter_q == '0) state_d = S_FIN;
      S_FIN:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
    endcase
  end

  // Recurrence step, rounding and result capture
  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    rem_d  = rem_q;
    iter_d = iter_q;
    tag_d  = tag_q;
    oq_d   = oq_q;
    oex_d  = oex_q;
    otag_d = otag_q;
    ovld_d = ovld_q;
    rem_sh = {rem_q[QW-1:0], r_q[RW-1 -: 2]};
    trial  = {q_q, 2'b01};
    ge     = (rem_sh >= trial);
    up     = (ROUND != 0) && (rem_q > {2'b00, q_q}) && !(&q_q);
    q_rnd  = q_q + QW'(up);
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r_d    = RW'(in_a) << SH;
          tag_d  = in_tag;
          q_d    = '0;
          rem_d  = '0;
          iter_d = IW'(QW - 1);
        end
      end
      S_CALC: begin
        r_d    = r_q << 2;
        rem_d  = ge ? (rem_sh - trial) : rem_sh;
        q_d    = {q_q[QW-2:0], ge};
        iter_d = iter_q - 1'b1;
      end
      S_FIN: begin
        oq_d   = q_rnd;
        oex_d  = (rem_q == '0);
        otag_d = tag_q;
        ovld_d = 1'b1;
      end
      S_DONE: begin
        if (out_ready) ovld_d = 1'b0;
      end
    endcase
  end

  // Port drive from state and result registers
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = ovld_q;
    out_q     = oq_q;
    out_exact = oex_q;
    out_tag   = otag_q;
  end

endmodule

// File: tb/tb_fxp_sqrt_seq.sv
// Bench for fxp_sqrt_seq: two default-width units (truncate / round)
// in lockstep plus a small rounding unit swept exhaustively.
module tb_fxp_sqrt_seq;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic        in_valid, out_ready;
  logic [11:0] in_a;
  logic [3:0]  in_tag;
  logic        in_ready0, out_valid0, out_exact0, busy0;
  logic [19:0] out_q0;
  logic [3:0]  out_tag0;
  logic        in_ready1, out_valid1, out_exact1, busy1;
  logic [19:0] out_q1;
  logic [3:0]  out_tag1;

  logic       s_valid, s_oready;
  logic [7:0] s_a;
  logic [3:0] s_tag;
  logic       s_ready, s_ovalid, s_exact, s_busy;
  logic [3:0] s_q, s_otag;

  fxp_sqrt_seq #(.ROUND(0)) dut0 (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_tag(in_tag), .out_valid(out_valid0),
    .out_ready(out_ready), .out_q(out_q0), .out_exact(out_exact0),
    .out_tag(out_tag0), .busy(busy0));

  fxp_sqrt_seq #(.ROUND(1)) dut1 (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_tag(in_tag), .out_valid(out_valid1),
    .out_ready(out_ready), .out_q(out_q1), .out_exact(out_exact1),
    .out_tag(out_tag1), .busy(busy1));

  fxp_sqrt_seq #(.IN_W(8), .IN_FRAC(0), .OUT_FRAC(0), .ROUND(1)) dut2 (
    .clk(clk), .rst_(rst_), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_tag(s_tag), .out_valid(s_ovalid),
    .out_ready(s_oready), .out_q(s_q), .out_exact(s_exact),
    .out_tag(s_otag), .busy(s_busy));

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input longint unsigned act,
                     input longint unsigned exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: true floor square root via real sqrt, corrected to integer
  function automatic longint unsigned isq(input longint unsigned r);
    longint unsigned q;
    q = longint'($floor($sqrt(real'(r))));
    while (q * q > r) q--;
    while ((q + 1) * (q + 1) <= r) q++;
    return q;
  endfunction

  function automatic longint unsigned model(input longint unsigned r,
      input int qw, input bit rnd, output bit ex);
    longint unsigned q, rem, top;
    q   = isq(r);
    rem = r - q * q;
    ex  = (rem == 0);
    top = (64'd1 << qw) - 1;
    if (rnd && (2 * rem > 2 * q) && q < top) q++;
    return q;
  endfunction

  // Edge counter for latency measurement
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [11:0] a;
    logic [3:0]  tag;
    int          e;
  } op_t;
  op_t sbq[$];

  logic        prev_ov;
  logic [19:0] prev_q;
  logic [3:0]  prev_tag;

  // Scoreboard for the default-width pair, sampled mid-cycle
  always @(negedge clk) begin
    op_t it;
    bit ex0, ex1;
    longint unsigned m0, m1, r;
    if (!rst_) begin
      sbq.delete();
      prev_ov <= 1'b0;
    end else begin
      chk("rdy_vs_busy", in_ready0, !busy0);
      if (in_valid && in_ready0)
        sbq.push_back('{a: in_a, tag: in_tag, e: edge_cnt + 1});
      if (out_valid0 && !prev_ov) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          it = sbq.pop_front();
          r  = longint'(it.a) << 28;
          m0 = model(r, 20, 1'b0, ex0);
          m1 = model(r, 20, 1'b1, ex1);
          chk("sb_q_trunc", out_q0, m0);
          chk("sb_exact", out_exact0, ex0);
          chk("sb_tag", out_tag0, it.tag);
          chk("sb_q_round", out_q1, m1);
          chk("sb_exact_r", out_exact1, ex1);
          chk("sb_ov_round", out_valid1, 1);
          chk("sb_latency", edge_cnt - it.e, 21);
        end
      end else if (out_valid0 && prev_ov) begin
        chk("hold_q", out_q0, prev_q);
        chk("hold_tag", out_tag0, prev_tag);
      end
      prev_ov  <= out_valid0;
      prev_q   <= out_q0;
      prev_tag <= out_tag0;
    end
  end

  logic [19:0] lq0, lq1;
  logic        lex0;
  int          llat;

  task automatic do_op(input logic [11:0] a, input logic [3:0] t,
                       input int hold);
    int n;
    @(posedge clk); #1;
    in_a = a; in_tag = t; in_valid = 1'b1; out_ready = (hold == 0);
    n = 0;
    while (!in_ready0 && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready0) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 12'($urandom);
    in_tag = 4'($urandom);
    n = 0;
    while (!out_valid0 && n < 200) begin @(posedge clk); #1; n++; end
    if (!out_valid0) chk("result_timeout", 0, 1);
    llat = n;
    lq0  = out_q0;
    lq1  = out_q1;
    lex0 = out_exact0;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ov_drop", out_valid0, 0);
  endtask

  logic [3:0] slq, sltag;
  logic       slex;

  task automatic s_op(input logic [7:0] a);
    int n;
    @(posedge clk); #1;
    s_a = a; s_tag = a[3:0] ^ 4'h5; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 0;
    while (!s_ovalid && n < 100) begin @(posedge clk); #1; n++; end
    if (!s_ovalid) chk("s_timeout", 0, 1);
    chk("s_latency", n, 5);
    slq = s_q; slex = s_exact; sltag = s_otag;
    @(posedge clk); #1;
  endtask

  initial begin
    bit ex;
    logic [19:0] hq;
    int n;
    rst_ = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_tag = '0;
    s_valid = 1'b0; s_a = '0; s_tag = '0; s_oready = 1'b1;

    // model pins
    chk("model_T1", model(64'h040 << 28, 20, 0, ex), 20'h20000);
    chk("model_T2", model(64'h020 << 28, 20, 0, ex), 20'h16A09);
    chk("model_T2r", model(64'h020 << 28, 20, 1, ex), 20'h16A0A);
    chk("model_T3", model(64'hFFF << 28, 20, 0, ex), 20'hFFF7F);
    chk("model_T3r", model(64'hFFF << 28, 20, 1, ex), 20'hFFF80);
    chk("model_T4", model(255, 4, 1, ex), 4'hF);

    #12;
    chk("rst_ov", out_valid0, 0);
    chk("rst_q", out_q0, 0);
    chk("rst_ex", out_exact0, 0);
    chk("rst_tag", out_tag0, 0);
    chk("rst_busy", busy0, 0);
    rst_ = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", in_ready0, 1);

    do_op(12'h040, 4'h1, 0);
    chk("t1_q", lq0, 20'h20000);
    chk("t1_ex", lex0, 1);
    chk("t1_lat", llat, 21);
    do_op(12'h020, 4'h2, 0);
    chk("t2_q", lq0, 20'h16A09);
    chk("t2_ex", lex0, 0);
    chk("t2_qr", lq1, 20'h16A0A);
    do_op(12'hFFF, 4'h3, 1);
    chk("t3_q", lq0, 20'hFFF7F);
    chk("t3_qr", lq1, 20'hFFF80);
    do_op(12'h000, 4'h4, 0);
    chk("t3_zero_q", lq0, 0);
    chk("t3_zero_ex", lex0, 1);
    chk("t3_zero_lat", llat, 21);

    // backpressure
    @(posedge clk); #1;
    out_ready = 1'b0; in_a = 12'h040; in_tag = 4'hA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t5_ov", out_valid0, 1);
    hq = out_q0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 12'h123; in_tag = 4'h3;
      @(posedge clk); #1;
      chk("t5_q", out_q0, 20'h20000);
      chk("t5_tag", out_tag0, 4'hA);
      chk("t5_rdy", in_ready0, 0);
      chk("t5_ov_hold", out_valid0, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_drop", out_valid0, 0);
    chk("t5_rdy1", in_ready0, 1);
    chk("t5_after_q", out_q0, hq);

    // reset mid-calculation
    @(posedge clk); #1;
    in_a = 12'h0A5; in_tag = 4'h6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t6_busy_pre", busy0, 1);
    rst_ = 1'b0;
    #1;
    chk("t6_ov", out_valid0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_q", out_q0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_ = 1'b1;
    do_op(12'h090, 4'h7, 0);
    chk("t6_new_q", lq0, 20'h30000);
    chk("t6_new_ex", lex0, 1);

    // randomized operations
    for (int i = 0; i < 40; i++)
      do_op(12'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

    // small rounding unit
    s_op(8'd255);
    chk("t4_255_q", slq, 4'hF);
    chk("t4_255_ex", slex, 0);
    s_op(8'd225);
    chk("t4_225_q", slq, 4'hF);
    chk("t4_225_ex", slex, 1);
    for (int v = 0; v < 256; v++) begin
      logic [7:0] av;
      av = 8'(v);
      s_op(av);
      chk("s_q", slq, model(longint'(v), 4, 1, ex));
      chk("s_ex", slex, ex);
      chk("s_tag", sltag, av[3:0] ^ 4'h5);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
